// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: byte-serial loader that assembles 3x3 operands A/B and fires the multiplier enable.
// Define MATRIX_LOADER_CKSUM_EN to require a trailing XOR checksum byte per frame.
module matrix_operand_loader #(
    parameter int ENABLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [71:0] A,
    output logic [71:0] B,
    output logic        enable_multiplication,
    output logic        frame_done,
    output logic        cksum_err
);
    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
`ifdef MATRIX_LOADER_CKSUM_EN
        LOAD_CK,
`endif
        FIRE
    } state_t;
    localparam logic [3:0] CNT_LOAD = 4'(ENABLE_CYCLES - 1);
    state_t state, state_n;
    logic [3:0] idx, cnt;
    logic accept, last;
    assign accept = in_valid && in_ready && !clear;
    assign last = idx == 4'd8;
`ifdef MATRIX_LOADER_CKSUM_EN
    logic [7:0] acc;
    logic ck_ok;
    assign ck_ok = in_data == acc;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD_A;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (clear) state_n = LOAD_A;
        else case (state)
            LOAD_A:  state_n = accept && last ? LOAD_B : LOAD_A;
`ifdef MATRIX_LOADER_CKSUM_EN
            LOAD_B:  state_n = accept && last ? LOAD_CK : LOAD_B;
            LOAD_CK: state_n = !accept ? LOAD_CK : ck_ok ? FIRE : LOAD_A;
`else
            LOAD_B:  state_n = accept && last ? FIRE : LOAD_B;
`endif
            FIRE:    state_n = cnt == 4'd0 ? LOAD_A : FIRE;
            default: state_n = LOAD_A;
        endcase
    end
    always_comb begin
        in_ready = !rst && state != FIRE;
    end
    // cnt idles at ENABLE_CYCLES-1 so it is already loaded on the edge that enters FIRE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            cnt <= '0;
            A <= '0;
            B <= '0;
            enable_multiplication <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            idx <= (clear || state_n != state) ? 4'd0 : accept ? idx + 4'd1 : idx;
            cnt <= state == FIRE ? cnt - 4'd1 : CNT_LOAD;
            if (accept && state == LOAD_A) A[{idx, 3'b000} +: 8] <= in_data;
            if (accept && state == LOAD_B) B[{idx, 3'b000} +: 8] <= in_data;
            enable_multiplication <= state_n == FIRE;
            frame_done <= !clear && state == FIRE && cnt == 4'd0;
        end
    end
`ifdef MATRIX_LOADER_CKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cksum_err <= 1'b0;
        end else begin
            acc <= (clear || (accept && state == LOAD_CK)) ? 8'd0 : accept ? acc ^ in_data : acc;
            cksum_err <= accept && state == LOAD_CK && !ck_ok;
        end
    end
`else
    assign cksum_err = 1'b0;
`endif
endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Byte-serial front end for the 3x3 8-bit matrix multiplier. Accepts a frame of 18 bytes (optionally 19) over a valid/ready byte stream and assembles the packed 72-bit operands `A` and `B`. Drives the multiplier's `enable_multiplication` for a fixed number of cycles with both operands held stable, then signals frame completion. It is the writer side of the multiplier's operand interface.

## Interface
- `ENABLE_CYCLES`, default 2: cycles `enable_multiplication` stays high per frame. Legal range 1..15. The multiplier needs 2 to present a fresh `result`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous frame abort.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader can accept a byte. A byte transfers on a rising edge where `in_valid && in_ready`.
- `A` out 72: packed matrix A, element [r][c] at bits `[8*(3r+c) +: 8]`.
- `B` out 72: packed matrix B, same packing as `A`.
- `enable_multiplication` out 1: multiplier enable.
- `frame_done` out 1: one-cycle pulse after the enable window.
- `cksum_err` out 1: one-cycle pulse on checksum mismatch. Tied 0 when checksum is compiled out.

## Operation
- States are LOAD_A, LOAD_B, LOAD_CK (checksum build only) and FIRE. Reset state is LOAD_A.
- Byte counter `idx` runs 0..8 and is cleared on every state change.
- **LOAD_A:** each accepted byte is written to `A[8*idx +: 8]`. Accepting the byte at `idx == 8` moves to LOAD_B.
- **LOAD_B:** same behaviour, writing into `B`. Accepting the byte at `idx == 8` moves to FIRE, or to LOAD_CK in the checksum build.
- **LOAD_CK:** accepts one byte.
  - If it equals the XOR of all 18 operand bytes, go to FIRE.
  - Otherwise pulse `cksum_err` and return to LOAD_A.
- **FIRE:**
  - `enable_multiplication = 1` for exactly ENABLE_CYCLES cycles, counted by a 4-bit down-counter.
  - Then return to LOAD_A with a `frame_done` pulse.
- `in_ready` is 1 in the LOAD states and 0 in FIRE and while `rst` is high.
- `A` and `B` change only on accepted bytes. They are stable throughout FIRE and are not cleared between frames.
- `in_valid` while `in_ready == 0` is ignored; no byte is consumed.
- **`clear`:**
  - In any state, forces LOAD_A, `idx = 0` and the checksum accumulator to 0, and drops `enable_multiplication` on the next edge.
  - No `frame_done` and no `cksum_err` are produced.
  - `clear` takes priority over a byte transfer in the same cycle; that byte is dropped.
- **Reset values:** `A = 0`, `B = 0`, `enable_multiplication = 0`, `frame_done = 0`, `cksum_err = 0`, `idx = 0`, state LOAD_A.
- **Reset mid-operation:** discards the partial frame and any enable window immediately (asynchronous).

## Timing
- All outputs except `in_ready` are registered. `in_ready` is decoded from state.
- Timeline for a frame whose final operand byte is accepted on edge k:
  - `enable_multiplication` is high in cycles k+1 .. k+ENABLE_CYCLES.
  - `frame_done` is high in cycle k+ENABLE_CYCLES+1.
  - `in_ready` returns to 1 in that same cycle.
- Checksum build: the timeline counts from the checksum byte's edge. `cksum_err` is high in cycle k+1.
- Throughput: one byte per cycle in the LOAD states. A back-to-back frame costs 18 (or 19) + ENABLE_CYCLES cycles.
- The multiplier's `result` is valid from cycle k+3 when ENABLE_CYCLES=2.

## Configuration
- `MATRIX_LOADER_CKSUM_EN` defined:
  - LOAD_CK state and an 8-bit XOR accumulator are present.
  - Frames are 19 bytes; `cksum_err` is live.
- `MATRIX_LOADER_CKSUM_EN` undefined:
  - No LOAD_CK state and no accumulator; frames are 18 bytes.
  - `cksum_err` is constant 0.

## Test plan
- **Basic frame:** stream bytes 1..9 then 10..18 with `in_valid` held high. Required:
  - `A = 72'h090807060504030201` and `B = 72'h121110_0F0E0D0C0B0A`.
  - `enable_multiplication` is high for exactly 2 cycles, then `frame_done` pulses once.
- **Throttled source:** A = identity (bytes 01,00,00,00,01,00,00,00,01) with `in_valid` toggling every cycle. Required:
  - `A = 72'h010000000100000001`.
  - No byte is lost or duplicated.
  - `in_ready` is 0 for the whole FIRE window.
- **Checksum (CKSUM_EN):** send bytes 1..18 followed by the checksum byte.
  - Checksum `8'h13` (XOR of 1..18): FIRE, then `frame_done`.
  - Checksum `8'h00`: `cksum_err` pulses, no enable, and the next byte is written into `A[7:0]`.
- **Reset mid-load:** assert `rst` after 5 bytes of B. Required:
  - All outputs are 0 asynchronously.
  - A following full frame loads correctly.
- **Clear during FIRE:** pulse `clear` in the first enable cycle. Required:
  - `enable_multiplication` is 0 on the next cycle.
  - No `frame_done`.
  - `in_ready` is 1.
- **Parameter sweep:** ENABLE_CYCLES=1 and 15. Required: enable width is exactly 1 and 15 cycles respectively, each followed by a single `frame_done`.
